mult_8_shift_add: RTL and testbench

- Sequential 8x8 unsigned shift-add multiplier. It is the control stage that drives the team's 8-bit ripple adder (a, b, cin -> sum, carry out) and consumes its result.
- The adder sits outside this block. It connects through the add_* ports and is purely combinational.
- Each iteration is one adder pass plus a right shift. A 16-bit product is produced in 8 iterations and reported with a start/busy/done handshake.

---
 rtl/mult_8_shift_add.sv | 69 ++++++
 tb/tb_mult_8_shift_add.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mult_8_shift_add.sv
// mult_8_shift_add: sequential unsigned shift-add multiplier driving an external combinational adder
module mult_8_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                   r_state;
  logic [WIDTH-1:0]         r_acc;
  logic [WIDTH-1:0]         r_mq;
  logic [WIDTH-1:0]         r_mcand;
  logic [$clog2(WIDTH)-1:0] r_count;
  logic [2*WIDTH-1:0]       r_product;
  logic [2*WIDTH-1:0]       w_shifted;
  logic                     w_calc;
  // The adder's carry-out becomes the new top bit, so the 17-bit sum+mq shifts right into 16 bits
  always_comb begin
    w_calc    = r_state == CALC;
    w_shifted = {add_cout, add_sum, r_mq[WIDTH-1:1]};
    add_a     = w_calc ? r_acc : '0;
    add_b     = (w_calc && r_mq[0]) ? r_mcand : '0;
    add_cin   = 1'b0;
    busy      = w_calc;
    done      = r_state == DONE;
    product   = r_product;
  end
  // Sequencer: capture operands on start, eight add-and-shift passes, one-cycle done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_mq      <= '0;
      r_mcand   <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_mcand <= a;
          r_mq    <= b;
          r_acc   <= '0;
          r_count <= '0;
          r_state <= CALC;
        end
        CALC: begin
          {r_acc, r_mq} <= w_shifted;
          r_count       <= r_count + 1'b1;
          if (r_count == WIDTH - 1) begin
            r_product <= w_shifted;
            r_state   <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_8_shift_add.sv
// tb_mult_8_shift_add: directed checks of the shift-add multiplier with a behavioural adder attached
module tb_mult_8_shift_add;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done, add_cin, add_cout;
  logic [15:0] product;
  logic [7:0]  add_a, add_b, add_sum;
  int          checks = 0;
  int          failures = 0;
  logic        cout_seen, addb_late;

  mult_8_shift_add #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mult(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string tag);
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    cout_seen = 1'b0;
    addb_late = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
      chk({tag, "_done_early"}, {15'd0, done}, 16'd0);
      chk({tag, "_cin"}, {15'd0, add_cin}, 16'd0);
      if (add_cout) cout_seen = 1'b1;
      if (c >= 2 && add_b != 8'd0) addb_late = 1'b1;
      tick();
    end
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_busy_done"}, {15'd0, busy}, 16'd0);
    chk({tag, "_product"}, product, exp);
    tick();
    chk({tag, "_done_drop"}, {15'd0, done}, 16'd0);
    chk({tag, "_product_hold"}, product, exp);
    chk({tag, "_adda_idle"}, {8'd0, add_a}, 16'd0);
  endtask

  initial begin
    #1;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_product", product, 16'd0);
    chk("rst_add_a", {8'd0, add_a}, 16'd0);
    chk("rst_add_b", {8'd0, add_b}, 16'd0);
    chk("rst_add_cin", {15'd0, add_cin}, 16'd0);
    tick();
    rst = 1'b0;
    tick();

    mult(8'd13, 8'd11, 16'h008F, "basic");
    mult(8'hFF, 8'hFF, 16'hFE01, "max");
    chk("max_cout_seen", {15'd0, cout_seen}, 16'd1);
    mult(8'h00, 8'hA5, 16'h0000, "zero");
    mult(8'hC8, 8'h01, 16'h00C8, "ident");
    chk("ident_addb_late", {15'd0, addb_late}, 16'd0);

    // start pulsed while busy must be ignored
    a = 8'd3; b = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) begin a = 8'd7; b = 8'd7; start = 1'b1; end
      if (c == 5) start = 1'b0;
      chk("busy_start_busy", {15'd0, busy}, 16'd1);
      tick();
    end
    chk("busy_start_done", {15'd0, done}, 16'd1);
    chk("busy_start_product", product, 16'h000F);
    for (int c = 10; c <= 20; c++) begin
      tick();
      chk("busy_start_no_second", {14'd0, busy, done}, 16'd0);
    end

    // reset in the middle of an operation
    a = 8'h10; b = 8'h10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("rstmid_busy_before", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", {15'd0, busy}, 16'd0);
    chk("rstmid_done", {15'd0, done}, 16'd0);
    chk("rstmid_product", product, 16'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rstmid_quiet", {14'd0, busy, done}, 16'd0);
      chk("rstmid_product_zero", product, 16'd0);
    end
    mult(8'd2, 8'd3, 16'h0006, "after_rst");

    // start held high: back-to-back multiplies every ten cycles
    a = 8'd4; b = 8'd4; start = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      chk("b2b1_busy", {15'd0, busy}, 16'd1);
      chk("b2b1_done_early", {15'd0, done}, 16'd0);
      tick();
    end
    chk("b2b1_done", {15'd0, done}, 16'd1);
    chk("b2b1_product", product, 16'h0010);
    tick();
    chk("b2b_gap", {14'd0, busy, done}, 16'd0);
    a = 8'd9; b = 8'd9;
    tick();
    for (int c = 11; c <= 18; c++) begin
      chk("b2b2_busy", {15'd0, busy}, 16'd1);
      chk("b2b2_done_early", {15'd0, done}, 16'd0);
      chk("b2b2_product_hold", product, 16'h0010);
      tick();
    end
    chk("b2b2_done", {15'd0, done}, 16'd1);
    chk("b2b2_product", product, 16'h0051);
    start = 1'b0;
    tick();
    chk("b2b2_done_drop", {15'd0, done}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
